tx_bit_timer: RTL

Parametrised transmit bit/byte timer for the USB TX path. Divides the system clock into bit periods, counts bits within a byte, and issues shift, early load-request and byte-done strobes to the TX shift register and encoder. Compared with the fixed 8×8 timer, it adds configurable period and byte length, a configurable load-request lead, synchronous restart, and a bit-stuffing stall that inserts a stuffed bit without advancing the bit count.

---
 rtl/tx_bit_timer_if.sv | 24 ++
 rtl/tx_bit_timer.sv | 82 ++++++++
 2 files changed

// File: rtl/tx_bit_timer_if.sv
// Control/strobe bundle between the TX controller (master) and tx_bit_timer (slave).
interface tx_bit_timer_if #(
  parameter int unsigned BITS_PER_BYTE = 8
);
  localparam int unsigned BW = $clog2(BITS_PER_BYTE);

  logic          timer_enable;
  logic          clear;
  logic          stuff_stall;
  logic          shift_strobe;
  logic          load_req;
  logic          byte_done;
  logic [BW-1:0] bit_index;

  modport master (
    output timer_enable, clear, stuff_stall,
    input  shift_strobe, load_req, byte_done, bit_index
  );

  modport slave (
    input  timer_enable, clear, stuff_stall,
    output shift_strobe, load_req, byte_done, bit_index
  );
endinterface

// File: rtl/tx_bit_timer.sv
// USB TX bit/byte timer: bit-period divider, bit counter and shift/load/done strobes.
// Optional TX_TIMER_STALL_EN: stuff_stall holds the bit count on a bit-end edge.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned LOAD_LEAD     = 1
) (
  input  logic           clk,
  input  logic           rst,
  tx_bit_timer_if.slave  tif
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(BITS_PER_BYTE);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_BYTE - 1);
  localparam logic [BW-1:0] LOAD_AT  = BW'(BITS_PER_BYTE - LOAD_LEAD);

  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [BW-1:0] bit_cnt_q,   bit_cnt_d;
  logic          shift_strobe_q, shift_strobe_d;
  logic          load_req_q,     load_req_d;
  logic          byte_done_q,    byte_done_d;
  logic          stall_c;

`ifdef TX_TIMER_STALL_EN
  assign stall_c = tif.stuff_stall;
`else
  logic unused_stuff_stall;
  assign unused_stuff_stall = tif.stuff_stall;
  assign stall_c = 1'b0;
`endif

  // Next-state: clear beats enable; strobes only on an enabled bit-end edge.
  always_comb begin
    cycle_cnt_d    = cycle_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_strobe_d = 1'b0;
    load_req_d     = 1'b0;
    byte_done_d    = 1'b0;
    if (tif.clear) begin
      cycle_cnt_d = '0;
      bit_cnt_d   = '0;
    end else if (tif.timer_enable) begin
      if (cycle_cnt_q == CYC_LAST) begin
        cycle_cnt_d    = '0;
        shift_strobe_d = 1'b1;
        if (!stall_c) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d  = bit_cnt_q + BW'(1);
            load_req_d = ((bit_cnt_q + BW'(1)) == LOAD_AT);
          end
        end
      end else begin
        cycle_cnt_d = cycle_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q    <= '0;
      bit_cnt_q      <= '0;
      shift_strobe_q <= 1'b0;
      load_req_q     <= 1'b0;
      byte_done_q    <= 1'b0;
    end else begin
      cycle_cnt_q    <= cycle_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_strobe_q <= shift_strobe_d;
      load_req_q     <= load_req_d;
      byte_done_q    <= byte_done_d;
    end
  end

  assign tif.shift_strobe = shift_strobe_q;
  assign tif.load_req     = load_req_q;
  assign tif.byte_done    = byte_done_q;
  assign tif.bit_index    = bit_cnt_q;
endmodule
